adc_block_accumulator: RTL and testbench
========================================

ADC_BLOCK_ACCUMULATOR -- requirements
Module: adc_block_accumulator

Interface
REQ-001 Parameters SHALL be: NUM_CH, 16, channel count; WIDTH, 18, signed sample width; ID, 8'hB0, packet ID byte.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ena  in  1  accumulate/emit enable.
REQ-006 block_trigger  in  1  block boundary, synchronous to clk, rising-edge sensitive.
REQ-007 in_valid  in  1  sample strobe.
REQ-008 in_ch_valid  in  NUM_CH  per-channel sample qualifier.
REQ-009 in_data  in  NUM_CH x WIDTH  signed channel samples.
REQ-010 in_timestamp  in  64  timestamp of current sample.
REQ-011 fifo_tdata  out  64  AXI-stream data.
REQ-012 fifo_tvalid, fifo_tlast  out  1 each  AXI-stream valid, last.
REQ-013 fifo_tready  in  1  AXI-stream ready.
REQ-014 drop_count  out  16  dropped-block counter (macro only, REQ-034).

Function
REQ-015 Per channel, when ena and in_valid and in_ch_valid[c]: sum[c] += sign-extended in_data[c]; nvalid[c] += 1; sum width WIDTH+16.
REQ-016 Block sample count SHALL increment on every accepted in_valid; saturate at 16'hFFFF; samples beyond saturation ignored for all channels; sticky flag SAT set.
REQ-017 First accepted sample of a block SHALL latch in_timestamp into block_ts; empty block reports block_ts = 0.
REQ-018 Trigger edge = block_trigger high, previous-cycle block_trigger low, ena high; edge ignored when ena low.
REQ-019 On trigger edge with emitter IDLE: sums, nvalid, count, block_ts, SAT copied to shadow registers; accumulators cleared same cycle; emitter to HDR next cycle.
REQ-020 Sample coincident with trigger edge SHALL belong to the new block (accumulators load with that sample, not zero).
REQ-021 On trigger edge with emitter not IDLE: block dropped, accumulators cleared, sticky DROP flag set; shadow unchanged.
REQ-022 Emitter states IDLE -> HDR -> TS -> DATA(NUM_CH words) -> IDLE; advance only on tvalid & tready.
REQ-023 HDR word: [63:56] ID, [55:48] seq, [47:32] count, [31:2] 0, [1] DROP, [0] SAT.
REQ-024 TS word: block_ts; DATA word c: [63:48] nvalid[c], [47:0] sum[c] sign-extended.
REQ-025 Packet length SHALL be exactly 2+NUM_CH words; tlast high only on DATA word NUM_CH-1.
REQ-026 tvalid SHALL stay high and tdata stable until accepted; no bubbles required.
REQ-027 seq SHALL increment (mod 256) after each emitted packet; DROP cleared when HDR accepted.
REQ-028 ena deassert SHALL clear accumulators next cycle; a packet in flight completes.

Reset
REQ-029 On rst: fifo_tvalid 0, fifo_tlast 0, fifo_tdata 0, state IDLE.
REQ-030 On rst: accumulators, shadow, count, seq, SAT, DROP, trigger history, drop_count all 0.
REQ-031 Reset mid-packet SHALL abort immediately; no partial resume after release.

Configuration
REQ-032 Macro ADC_BLOCK_ACCUMULATOR_DROPCNT_EN selects drop counting.
REQ-033 Without it: drop_count port absent; DROP flag only.
REQ-034 With it: drop_count increments per REQ-021 event, saturates at 16'hFFFF, never self-clears.

Verification
REQ-035 ena=1, 4 valid samples ch0=+3 all ch_valid, trigger, tready=1 -> 18 words: HDR count=4 seq=0, DATA0 = {16'd4, 48'd12}, tlast on word 18.
REQ-036 ch5 samples -131072 x2, ch_valid[5]=1 only -> DATA5 = {16'd2, 48'hFFFF_FFFC_0000}, other channels {0,0}.
REQ-037 tready=0 during packet, second trigger -> packet unchanged; next packet HDR bit1=1; drop_count=1 (macro on).
REQ-038 Trigger with coincident valid sample +7 -> old block excludes it; next packet count includes it.
REQ-039 rst asserted mid-DATA -> tvalid 0 same cycle; after release next packet seq=0.
REQ-040 70000 samples then trigger -> count 16'hFFFF, SAT=1, nvalid 65535.

Source files
------------

// File: rtl/adc_block_accumulator.sv
// Per-channel block accumulator that emits each closed block as a 2+NUM_CH word AXI-stream packet.
// Define ADC_BLOCK_ACCUMULATOR_DROPCNT_EN to add the saturating drop_count output.
module adc_block_accumulator #(
  parameter int         NUM_CH = 16,
  parameter int         WIDTH  = 18,
  parameter logic [7:0] ID     = 8'hB0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    block_trigger,
  input  logic                    in_valid,
  input  logic [NUM_CH-1:0]       in_ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [63:0]             in_timestamp,
  output logic [63:0]             fifo_tdata,
  output logic                    fifo_tvalid,
  output logic                    fifo_tlast,
  input  logic                    fifo_tready
`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);
  localparam int SW = WIDTH + 16;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, TS, DATA} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [7:0]                 seq_q, seq_d;
  logic [NUM_CH-1:0][SW-1:0]  sum_q, sum_d, sh_sum_q, sh_sum_d;
  logic [NUM_CH-1:0][15:0]    nv_q, nv_d, sh_nv_q, sh_nv_d;
  logic [15:0]                cnt_q, cnt_d, sh_cnt_q, sh_cnt_d;
  logic [63:0]                ts_q, ts_d, sh_ts_q, sh_ts_d;
  logic                       sat_q, sat_d, sh_sat_q, sh_sat_d;
  logic                       drop_q, drop_d, sh_drop_q, sh_drop_d;
  logic                       trig_prev_q, trig_prev_d;
  logic                       trig;

  assign trig_prev_d = block_trigger;
  assign trig        = block_trigger && !trig_prev_q && ena;

  // A sample coincident with the trigger lands in the freshly cleared block.
  always_comb begin
    sum_d = sum_q;
    nv_d  = nv_q;
    cnt_d = cnt_q;
    ts_d  = ts_q;
    sat_d = sat_q;
    if (!ena || trig) begin
      sum_d = '0;
      nv_d  = '0;
      cnt_d = '0;
      ts_d  = '0;
      sat_d = 1'b0;
    end
    if (ena && in_valid) begin
      if (cnt_d == 16'hFFFF) begin
        sat_d = 1'b1;
      end else begin
        if (cnt_d == 16'd0) ts_d = in_timestamp;
        cnt_d = cnt_d + 16'd1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (in_ch_valid[c]) begin
            sum_d[c] = sum_d[c] + {{16{in_data[c*WIDTH+WIDTH-1]}}, in_data[c*WIDTH +: WIDTH]};
            nv_d[c]  = nv_d[c] + 16'd1;
          end
        end
      end
    end
  end

  // DROP moves into the shadow with the block it precedes, so a stalled header never changes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    sh_sum_d  = sh_sum_q;
    sh_nv_d   = sh_nv_q;
    sh_cnt_d  = sh_cnt_q;
    sh_ts_d   = sh_ts_q;
    sh_sat_d  = sh_sat_q;
    sh_drop_d = sh_drop_q;
    drop_d    = drop_q;
    if (trig) begin
      if (state_q == IDLE) begin
        sh_sum_d  = sum_q;
        sh_nv_d   = nv_q;
        sh_cnt_d  = cnt_q;
        sh_ts_d   = ts_q;
        sh_sat_d  = sat_q;
        sh_drop_d = drop_q;
        drop_d    = 1'b0;
        state_d   = HDR;
      end else begin
        drop_d = 1'b1;
      end
    end
    if (fifo_tready) begin
      case (state_q)
        HDR: state_d = TS;
        TS: begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          if (idx_q == IW'(NUM_CH - 1)) begin
            state_d = IDLE;
            seq_d   = seq_q + 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo_tdata = '0;
    case (state_q)
      HDR:  fifo_tdata = {ID, seq_q, sh_cnt_q, 30'd0, sh_drop_q, sh_sat_q};
      TS:   fifo_tdata = sh_ts_q;
      DATA: fifo_tdata = {sh_nv_q[idx_q], {(48-SW){sh_sum_q[idx_q][SW-1]}}, sh_sum_q[idx_q]};
      default: ;
    endcase
  end

  assign fifo_tvalid = (state_q != IDLE);
  assign fifo_tlast  = (state_q == DATA) && (idx_q == IW'(NUM_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seq_q       <= '0;
      sum_q       <= '0;
      nv_q        <= '0;
      cnt_q       <= '0;
      ts_q        <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      sh_sum_q    <= '0;
      sh_nv_q     <= '0;
      sh_cnt_q    <= '0;
      sh_ts_q     <= '0;
      sh_sat_q    <= 1'b0;
      sh_drop_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      sum_q       <= sum_d;
      nv_q        <= nv_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      sh_sum_q    <= sh_sum_d;
      sh_nv_q     <= sh_nv_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_ts_q     <= sh_ts_d;
      sh_sat_q    <= sh_sat_d;
      sh_drop_q   <= sh_drop_d;
      trig_prev_q <= trig_prev_d;
    end
  end

`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
  logic        drop_evt;
  logic [15:0] dcnt_q, dcnt_d;

  assign drop_evt = trig && (state_q != IDLE);

  always_comb begin
    dcnt_d = dcnt_q;
    if (drop_evt && dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dcnt_q <= '0;
    else     dcnt_q <= dcnt_d;
  end

  assign drop_count = dcnt_q;
`endif
endmodule

// File: tb/tb_adc_block_accumulator.sv
// Randomized and directed bench for adc_block_accumulator against an arithmetic block/packet model.
module tb_adc_block_accumulator;
  localparam int         NUM_CH = 16;
  localparam int         WIDTH  = 18;
  localparam int         NW     = NUM_CH + 2;
  localparam logic [7:0] ID     = 8'hB0;

  logic                    clk = 1'b0;
  logic                    rst, ena, block_trigger, in_valid, fifo_tready;
  logic [NUM_CH-1:0]       in_ch_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [63:0]             in_timestamp, fifo_tdata;
  logic                    fifo_tvalid, fifo_tlast;
`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
  logic [15:0]             drop_count;
`endif

  int checks = 0;
  int errors = 0;

  longint      m_sum [NUM_CH];
  int          m_nv  [NUM_CH];
  int          m_cnt, m_seq, m_dcnt, words_left;
  logic [63:0] m_ts;
  bit          m_sat, m_drop, m_prev;
  logic [63:0] expq[$];
  logic [63:0] got[$];

  adc_block_accumulator dut (
    .clk(clk), .rst(rst), .ena(ena), .block_trigger(block_trigger),
    .in_valid(in_valid), .in_ch_valid(in_ch_valid), .in_data(in_data),
    .in_timestamp(in_timestamp), .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid),
    .fifo_tlast(fifo_tlast), .fifo_tready(fifo_tready)
`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sample(input int c);
    longint v;
    v = longint'(in_data[c*WIDTH +: WIDTH]);
    if (v >= (longint'(1) << (WIDTH - 1))) v = v - (longint'(1) << WIDTH);
    return v;
  endfunction

  task automatic clear_block();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sum[c] = 0;
      m_nv[c]  = 0;
    end
    m_cnt = 0;
    m_ts  = '0;
    m_sat = 1'b0;
  endtask

  task automatic model_reset();
    clear_block();
    m_seq = 0; m_dcnt = 0; words_left = 0;
    m_drop = 1'b0; m_prev = 1'b0;
    expq.delete();
  endtask

  // Called just after a falling edge: check outputs, advance the model over the next rising edge.
  task automatic tick();
    bit          tedge, busy;
    logic [63:0] s;
    chk("tvalid", 64'(fifo_tvalid), 64'(words_left > 0));
    if (words_left > 0) begin
      chk("tdata", fifo_tdata, expq[0]);
      chk("tlast", 64'(fifo_tlast), 64'(words_left == 1));
    end
    if (fifo_tvalid && fifo_tready) got.push_back(fifo_tdata);
    busy = (words_left > 0);
    if (busy && fifo_tready) begin
      void'(expq.pop_front());
      words_left--;
    end
    tedge  = block_trigger && !m_prev && ena;
    m_prev = block_trigger;
    if (tedge) begin
      if (!busy) begin
        expq.push_back({ID, 8'(m_seq), 16'(m_cnt), 30'd0, m_drop, m_sat});
        expq.push_back(m_ts);
        for (int c = 0; c < NUM_CH; c++) begin
          s = 64'(m_sum[c]);
          expq.push_back({16'(m_nv[c]), s[47:0]});
        end
        words_left = NW;
        m_seq  = (m_seq + 1) % 256;
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        if (m_dcnt < 65535) m_dcnt++;
      end
    end
    if (!ena || tedge) clear_block();
    if (ena && in_valid) begin
      if (m_cnt == 65535) m_sat = 1'b1;
      else begin
        if (m_cnt == 0) m_ts = in_timestamp;
        m_cnt++;
        for (int c = 0; c < NUM_CH; c++)
          if (in_ch_valid[c]) begin
            m_sum[c] += sample(c);
            m_nv[c]++;
          end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse();
    block_trigger = 1'b1;
    tick();
    block_trigger = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (words_left > 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(words_left), 64'd0);
  endtask

  task automatic rand_data();
    for (int c = 0; c < NUM_CH; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    in_timestamp = {$urandom, $urandom};
  endtask

  task automatic samples(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_data();
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    rst = 1'b1; ena = 1'b0; block_trigger = 1'b0; in_valid = 1'b0;
    in_ch_valid = '0; in_data = '0; in_timestamp = '0; fifo_tready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(fifo_tvalid), 64'd0);
    chk("rst_tlast", 64'(fifo_tlast), 64'd0);
    chk("rst_tdata", fifo_tdata, 64'd0);
`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
    chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    rst = 1'b0; ena = 1'b1; fifo_tready = 1'b1;

    // four +3 samples on ch0, all channels qualified
    in_data = '0; in_ch_valid = '1; in_data[0 +: WIDTH] = WIDTH'(3); in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_timestamp = 64'(100 + i); tick(); end
    in_valid = 1'b0; got.delete();
    pulse(); drain();
    chk("basic_len", 64'(got.size()), 64'(NW));
    w = got[0];
    chk("basic_hdr_count", 64'(w[47:32]), 64'd4);
    chk("basic_hdr_seq", 64'(w[55:48]), 64'd0);
    chk("basic_ts", got[1], 64'd100);
    chk("basic_data0", got[2], {16'd4, 48'd12});

    // negative full-scale on ch5 only
    in_data = '0; in_ch_valid = NUM_CH'(1) << 5; in_data[5*WIDTH +: WIDTH] = 18'h20000;
    in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    got.delete(); pulse(); drain();
    chk("neg_data5", got[2+5], {16'd2, 48'hFFFF_FFFC_0000});
    chk("neg_data0", got[2], 64'd0);

    // stalled packet, second trigger is dropped
    in_ch_valid = '1; samples(3);
    fifo_tready = 1'b0; got.delete(); pulse();
    repeat (3) tick();
    samples(2);
    pulse();
    repeat (2) tick();
    fifo_tready = 1'b1; drain();
    w = got[0];
    chk("stall_hdr_drop", 64'(w[1]), 64'd0);
`ifdef ADC_BLOCK_ACCUMULATOR_DROPCNT_EN
    chk("drop_count_one", 64'(drop_count), 64'd1);
`endif
    samples(2); got.delete(); pulse(); drain();
    w = got[0];
    chk("next_hdr_drop", 64'(w[1]), 64'd1);

    // sample coincident with trigger belongs to the new block
    samples(3);
    in_data = '0; in_data[0 +: WIDTH] = WIDTH'(7); in_valid = 1'b1;
    got.delete(); pulse(); in_valid = 1'b0; drain();
    w = got[0];
    chk("coinc_old_count", 64'(w[47:32]), 64'd3);
    got.delete(); pulse(); drain();
    w = got[0];
    chk("coinc_new_count", 64'(w[47:32]), 64'd1);
    chk("coinc_new_data0", got[2], {16'd1, 48'd7});

    // random traffic
    for (int i = 0; i < 500; i++) begin
      ena           = ($urandom_range(15) != 0);
      in_valid      = $urandom_range(1);
      in_ch_valid   = NUM_CH'($urandom);
      block_trigger = ($urandom_range(24) == 0);
      fifo_tready   = ($urandom_range(3) != 0);
      rand_data();
      tick();
    end
    ena = 1'b1; in_valid = 1'b0; block_trigger = 1'b0; fifo_tready = 1'b1;
    tick(); drain();

    // reset in the middle of the DATA words
    samples(2); pulse();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(fifo_tvalid), 64'd0);
    chk("midrst_tdata", fifo_tdata, 64'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    samples(2); got.delete(); pulse(); drain();
    w = got[0];
    chk("midrst_seq", 64'(w[55:48]), 64'd0);

    // count saturation
    in_ch_valid = '1; samples(70000);
    got.delete(); pulse(); drain();
    w = got[0];
    chk("sat_count", 64'(w[47:32]), 64'hFFFF);
    chk("sat_flag", 64'(w[0]), 64'd1);
    w = got[2];
    chk("sat_nvalid", 64'(w[63:48]), 64'd65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
